riscv_mcyc_ctrl: RTL and testbench

Multi-cycle stage sequencer for the next-generation RV32 core. It replaces the single-cycle, combinational IFU->IDU->EXU->LSU->WBU flow with a state machine that handshakes with variable-latency instruction and data memories. It owns the architectural PC and gates register-file writes, so that each instruction retires exactly once. It sits beside riscv_idu, riscv_exu and riscv_lsu in the core top and also provides halt/trap status and cycle/instret counters.

---
 rtl/riscv_defs.sv | 32 +++
 rtl/riscv_perf_cnt.sv | 30 +++
 rtl/riscv_mcyc_ctrl.sv | 152 +++++++++++++++
 tb/tb_riscv_mcyc_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// ----------------------------------------------------------------------------
// riscv_defs : shared state, trap-cause and reset-PC definitions for the core
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package riscv_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [3:0] {
    ST_RST        = 4'd0,
    ST_FETCH_REQ  = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_EXEC       = 4'd3,
    ST_MEM_REQ    = 4'd4,
    ST_MEM_WAIT   = 4'd5,
    ST_WB         = 4'd6,
    ST_HALT       = 4'd7,
    ST_TRAP       = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_FETCH_ERR = 2'd0,
    CAUSE_DATA_ERR  = 2'd1,
    CAUSE_TIMEOUT   = 2'd2,
    CAUSE_MISALIGN  = 2'd3
  } cause_t;

endpackage

`default_nettype wire

// File: rtl/riscv_perf_cnt.sv
// ----------------------------------------------------------------------------
// riscv_perf_cnt : paired cycle / retired-instruction counters, wrap on overflow
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module riscv_perf_cnt #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cyc_en,
  input  logic                 ret_en,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (cyc_en) cycle_cnt   <= cycle_cnt + 1'b1;
      if (ret_en) instret_cnt <= instret_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_mcyc_ctrl.sv
// ----------------------------------------------------------------------------
// riscv_mcyc_ctrl : multi-cycle fetch/exec/mem/writeback sequencer for RV32
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module riscv_mcyc_ctrl
  import riscv_defs::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int              CNT_WIDTH = 64,
  parameter int              TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ifu_req_valid,
  input  logic                 ifu_req_ready,
  output logic [XLEN-1:0]      ifu_req_addr,
  input  logic                 ifu_rsp_valid,
  input  logic [31:0]          ifu_rsp_inst,
  input  logic                 ifu_rsp_err,
  output logic [31:0]          inst,
  input  logic                 dec_mem,
  input  logic                 dec_rd_wen,
  input  logic                 dec_ebreak,
  input  logic [XLEN-1:0]      next_pc,
  output logic                 lsu_req_valid,
  input  logic                 lsu_req_ready,
  input  logic                 lsu_rsp_valid,
  input  logic                 lsu_rsp_err,
  output logic                 rf_wen,
  output logic [XLEN-1:0]      pc,
  output logic                 halt,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  cause_t              cause_d;
  logic                trap_enter;
  logic [WAIT_W-1:0]   wait_q;
  logic                timed_out;
  logic                pc_aligned;
  logic                in_wait;

  assign timed_out  = (wait_q == WAIT_W'(TIMEOUT));
  assign pc_aligned = (next_pc[1:0] == 2'b00);
  assign in_wait    = (state_q == ST_FETCH_WAIT) || (state_q == ST_MEM_WAIT);

  always_comb begin
    state_d    = state_q;
    cause_d    = CAUSE_FETCH_ERR;
    trap_enter = 1'b0;
    case (state_q)
      ST_RST:       state_d = ST_FETCH_REQ;
      ST_FETCH_REQ: if (ifu_req_ready) state_d = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        // A response in the same cycle as the timeout takes priority.
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            trap_enter = 1'b1;
            cause_d    = CAUSE_FETCH_ERR;
          end else begin
            state_d = ST_EXEC;
          end
        end else if (timed_out) begin
          trap_enter = 1'b1;
          cause_d    = CAUSE_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (dec_ebreak)   state_d = ST_HALT;
        else if (dec_mem) state_d = ST_MEM_REQ;
        else              state_d = ST_WB;
      end
      ST_MEM_REQ: if (lsu_req_ready) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          if (lsu_rsp_err) begin
            trap_enter = 1'b1;
            cause_d    = CAUSE_DATA_ERR;
          end else begin
            state_d = ST_WB;
          end
        end else if (timed_out) begin
          trap_enter = 1'b1;
          cause_d    = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        if (pc_aligned) begin
          state_d = ST_FETCH_REQ;
        end else begin
          trap_enter = 1'b1;
          cause_d    = CAUSE_MISALIGN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
    if (trap_enter) state_d = ST_TRAP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RST;
      pc         <= RESET_PC;
      inst       <= '0;
      halt       <= 1'b0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
      wait_q     <= '0;
    end else begin
      state_q <= state_d;
      // Counter restarts whenever a wait state is entered or left.
      if (in_wait && (state_d == state_q)) wait_q <= wait_q + 1'b1;
      else                                 wait_q <= '0;
      if ((state_q == ST_FETCH_WAIT) && ifu_rsp_valid) inst <= ifu_rsp_inst;
      if ((state_q == ST_WB) && pc_aligned) pc <= next_pc;
      if (state_d == ST_HALT) halt <= 1'b1;
      if (trap_enter) begin
        trap       <= 1'b1;
        trap_cause <= cause_d;
      end
    end
  end

  assign ifu_req_valid = (state_q == ST_FETCH_REQ);
  assign ifu_req_addr  = pc;
  assign lsu_req_valid = (state_q == ST_MEM_REQ);
  assign rf_wen        = (state_q == ST_WB) && dec_rd_wen && pc_aligned;

  riscv_perf_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .cyc_en      ((state_q != ST_RST) && (state_q != ST_HALT) && (state_q != ST_TRAP)),
    .ret_en      ((state_q == ST_WB) && pc_aligned),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_riscv_mcyc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_riscv_mcyc_ctrl : directed self-checking bench for the multi-cycle sequencer
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_riscv_mcyc_ctrl;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_inst, inst;
  logic        dec_mem, dec_rd_wen, dec_ebreak;
  logic [31:0] next_pc;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic        rf_wen;
  logic [31:0] pc;
  logic        halt, trap;
  logic [1:0]  trap_cause;
  logic [63:0] cycle_cnt, instret_cnt;

  int n_cmp = 0;
  int n_err = 0;

  riscv_mcyc_ctrl #(
    .XLEN      (32),
    .RESET_PC  (RPC),
    .CNT_WIDTH (64),
    .TIMEOUT   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_inst  (ifu_rsp_inst),
    .ifu_rsp_err   (ifu_rsp_err),
    .inst          (inst),
    .dec_mem       (dec_mem),
    .dec_rd_wen    (dec_rd_wen),
    .dec_ebreak    (dec_ebreak),
    .next_pc       (next_pc),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_err   (lsu_rsp_err),
    .rf_wen        (rf_wen),
    .pc            (pc),
    .halt          (halt),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = 0; ifu_rsp_err = 0;
    dec_mem = 0; dec_rd_wen = 0; dec_ebreak = 0; next_pc = 0;
    lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
  endtask

  // Leaves the DUT in FETCH_REQ with counters at zero.
  task automatic do_reset();
    clear_inputs();
    rst = 1; tick();
    rst = 0; tick();
  endtask

  // From FETCH_REQ, zero-wait fetch of w; leaves the DUT in EXEC.
  task automatic fetch(input logic [31:0] w);
    ifu_req_ready = 1; tick();
    ifu_req_ready = 0; ifu_rsp_valid = 1; ifu_rsp_inst = w; tick();
    ifu_rsp_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; tick();
    n_cmp++; if (pc !== RPC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RPC); end
    n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", inst); end
    n_cmp++; if ({ifu_req_valid, lsu_req_valid, rf_wen, halt, trap} !== 5'b0) begin n_err++;
      $display("FAIL reset_ctrl: got %b want 00000", {ifu_req_valid, lsu_req_valid, rf_wen, halt, trap}); end
    n_cmp++; if (trap_cause !== 2'd0) begin n_err++; $display("FAIL reset_cause: got %0d want 0", trap_cause); end
    n_cmp++; if ({cycle_cnt, instret_cnt} !== 128'h0) begin n_err++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, instret_cnt); end
    rst = 0; tick();
    n_cmp++; if (ifu_req_valid !== 1'b1 || ifu_req_addr !== RPC) begin n_err++;
      $display("FAIL reset_first_fetch: got v=%b a=%h want v=1 a=%h", ifu_req_valid, ifu_req_addr, RPC); end
    n_cmp++; if (cycle_cnt !== 64'd0) begin n_err++; $display("FAIL reset_rst_nocount: got %0d want 0", cycle_cnt); end
  endtask

  task automatic test_addi();
    do_reset();
    fetch(32'h0010_0093);
    n_cmp++; if (inst !== 32'h0010_0093) begin n_err++; $display("FAIL addi_inst: got %h want 00100093", inst); end
    n_cmp++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL addi_exec_wen: got %b want 0", rf_wen); end
    dec_rd_wen = 1; next_pc = RPC + 4; tick();
    n_cmp++; if (rf_wen !== 1'b1) begin n_err++; $display("FAIL addi_wb_wen: got %b want 1", rf_wen); end
    n_cmp++; if (pc !== RPC) begin n_err++; $display("FAIL addi_wb_pc: got %h want %h", pc, RPC); end
    tick();
    n_cmp++; if (pc !== 32'h8000_0004) begin n_err++; $display("FAIL addi_pc: got %h want 80000004", pc); end
    n_cmp++; if (instret_cnt !== 64'd1) begin n_err++; $display("FAIL addi_instret: got %0d want 1", instret_cnt); end
    n_cmp++; if (cycle_cnt !== 64'd4) begin n_err++; $display("FAIL addi_cycles: got %0d want 4", cycle_cnt); end
    n_cmp++; if (rf_wen !== 1'b0 || ifu_req_valid !== 1'b1) begin n_err++;
      $display("FAIL addi_refetch: got wen=%b v=%b want wen=0 v=1", rf_wen, ifu_req_valid); end
    n_cmp++; if (ifu_req_addr !== 32'h8000_0004) begin n_err++; $display("FAIL addi_addr: got %h want 80000004", ifu_req_addr); end
  endtask

  task automatic test_load();
    int wen_pulses;
    wen_pulses = 0;
    do_reset();
    fetch(32'h0002_a303);
    dec_mem = 1; dec_rd_wen = 1; next_pc = RPC + 4;
    // Early stale data response in EXEC must be ignored.
    lsu_rsp_valid = 1; tick(); lsu_rsp_valid = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (lsu_req_valid !== 1'b1 || pc !== RPC) begin n_err++;
        $display("FAIL load_req_hold%0d: got v=%b pc=%h want v=1 pc=%h", i, lsu_req_valid, pc, RPC); end
      if (rf_wen) wen_pulses++;
      if (i == 3) lsu_req_ready = 1;
      tick();
    end
    lsu_req_ready = 0;
    n_cmp++; if (lsu_req_valid !== 1'b0) begin n_err++; $display("FAIL load_req_drop: got %b want 0", lsu_req_valid); end
    if (rf_wen) wen_pulses++;
    tick();
    if (rf_wen) wen_pulses++;
    lsu_rsp_valid = 1; tick(); lsu_rsp_valid = 0;
    n_cmp++; if (rf_wen !== 1'b1) begin n_err++; $display("FAIL load_wb_wen: got %b want 1", rf_wen); end
    if (rf_wen) wen_pulses++;
    tick();
    if (rf_wen) wen_pulses++;
    n_cmp++; if (wen_pulses != 1) begin n_err++; $display("FAIL load_wen_pulses: got %0d want 1", wen_pulses); end
    n_cmp++; if (instret_cnt !== 64'd1 || cycle_cnt !== 64'd10) begin n_err++;
      $display("FAIL load_counts: got %0d/%0d want 1/10", instret_cnt, cycle_cnt); end
    n_cmp++; if (pc !== 32'h8000_0004) begin n_err++; $display("FAIL load_pc: got %h want 80000004", pc); end
  endtask

  task automatic test_ebreak();
    do_reset();
    fetch(32'h0010_0073);
    n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL ebreak_exec_halt: got %b want 0", halt); end
    dec_ebreak = 1; dec_rd_wen = 1; next_pc = RPC + 4; tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (halt !== 1'b1 || trap !== 1'b0 || ifu_req_valid !== 1'b0 || rf_wen !== 1'b0) begin n_err++;
        $display("FAIL ebreak_halt%0d: got h=%b t=%b v=%b w=%b want 1 0 0 0", i, halt, trap, ifu_req_valid, rf_wen); end
      n_cmp++; if (cycle_cnt !== 64'd3 || instret_cnt !== 64'd0) begin n_err++;
        $display("FAIL ebreak_frozen%0d: got %0d/%0d want 3/0", i, cycle_cnt, instret_cnt); end
      tick();
    end
  endtask

  task automatic test_fetch_err();
    do_reset();
    dec_rd_wen = 1; next_pc = RPC + 4;
    ifu_req_ready = 1; tick(); ifu_req_ready = 0;
    ifu_rsp_valid = 1; ifu_rsp_err = 1; tick();
    ifu_rsp_valid = 0; ifu_rsp_err = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (trap !== 1'b1 || trap_cause !== 2'd0) begin n_err++;
        $display("FAIL ferr_trap%0d: got t=%b c=%0d want t=1 c=0", i, trap, trap_cause); end
      n_cmp++; if (pc !== RPC || rf_wen !== 1'b0 || ifu_req_valid !== 1'b0) begin n_err++;
        $display("FAIL ferr_quiet%0d: got pc=%h w=%b v=%b want %h 0 0", i, pc, rf_wen, ifu_req_valid, RPC); end
      tick();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ifu_req_ready = 1; tick(); ifu_req_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (trap !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", trap); end
    tick();
    n_cmp++; if (trap !== 1'b1 || trap_cause !== 2'd2) begin n_err++;
      $display("FAIL tmo_trap: got t=%b c=%0d want t=1 c=2", trap, trap_cause); end
    // Response in the last allowed cycle beats the timeout.
    do_reset();
    ifu_req_ready = 1; tick(); ifu_req_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    ifu_rsp_valid = 1; ifu_rsp_inst = 32'h0000_0013; tick(); ifu_rsp_valid = 0;
    n_cmp++; if (trap !== 1'b0 || inst !== 32'h0000_0013) begin n_err++;
      $display("FAIL tmo_rsp_wins: got t=%b inst=%h want t=0 inst=00000013", trap, inst); end
    dec_rd_wen = 1; next_pc = RPC + 8; tick();
    n_cmp++; if (rf_wen !== 1'b1) begin n_err++; $display("FAIL tmo_rsp_wb: got %b want 1", rf_wen); end
  endtask

  task automatic test_rst_mid_and_misalign();
    do_reset();
    fetch(32'h0010_0093);
    dec_rd_wen = 1; next_pc = RPC + 4; tick(); tick();
    fetch(32'h0002_a303);
    dec_mem = 1; tick();
    lsu_req_ready = 1; tick(); lsu_req_ready = 0;
    rst = 1; lsu_rsp_valid = 1; tick();
    n_cmp++; if (pc !== RPC || cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin n_err++;
      $display("FAIL rstmid_state: got pc=%h %0d/%0d want %h 0/0", pc, cycle_cnt, instret_cnt, RPC); end
    n_cmp++; if ({ifu_req_valid, lsu_req_valid, rf_wen} !== 3'b0) begin n_err++;
      $display("FAIL rstmid_outs: got %b want 000", {ifu_req_valid, lsu_req_valid, rf_wen}); end
    rst = 0; dec_mem = 0; tick();
    lsu_rsp_valid = 0;
    n_cmp++; if (ifu_req_valid !== 1'b1 || rf_wen !== 1'b0 || instret_cnt !== 64'd0) begin n_err++;
      $display("FAIL rstmid_stale: got v=%b w=%b ir=%0d want 1 0 0", ifu_req_valid, rf_wen, instret_cnt); end
    fetch(32'h0010_0093);
    dec_rd_wen = 1; next_pc = 32'h8000_0002; tick();
    n_cmp++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL mis_wen: got %b want 0", rf_wen); end
    tick();
    n_cmp++; if (trap !== 1'b1 || trap_cause !== 2'd3) begin n_err++;
      $display("FAIL mis_trap: got t=%b c=%0d want t=1 c=3", trap, trap_cause); end
    n_cmp++; if (pc !== RPC || instret_cnt !== 64'd0) begin n_err++;
      $display("FAIL mis_noretire: got pc=%h ir=%0d want %h 0", pc, instret_cnt, RPC); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_addi();
    test_load();
    test_ebreak();
    test_fetch_err();
    test_timeout();
    test_rst_mid_and_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
